// File: rtl/uart_rx_fifo.sv
// UART receive byte buffer: synchronizes the receiver's data-ready level,
// captures one byte per rising edge into a first-word-fall-through FIFO.
// Ports: clk, rst (async, active-low), din/d_rdy_in (receiver side),
//   dout/dout_valid/dout_ready (consumer handshake),
//   count/full/empty (fill status), overrun/clr_ovr (sticky drop flag).
module uart_rx_fifo #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        din,
  input  logic              d_rdy_in,
  output logic [7:0]        dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overrun,
  input  logic              clr_ovr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  logic              s1, s2, s3;
  logic              wr_req;
  logic              push, pop, drop;
  logic [ADDR_W:0]   wr_ptr, rd_ptr;
  logic [7:0]        mem [DEPTH];

  // s3 is a history flop; it resets to 0 so a level already
  // high when reset releases still yields exactly one capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d_rdy_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign wr_req = s2 & ~s3;

  assign count      = wr_ptr - rd_ptr;
  assign full       = (count == DEPTH_V);
  assign empty      = (count == '0);
  assign dout_valid = ~empty;

  assign pop  = dout_valid & dout_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign push = wr_req & (~full | pop);
  assign drop = wr_req & full & ~pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage holds no reset value; dout is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[ADDR_W-1:0]] <= din;
  end

  assign dout = empty ? 8'h00 : mem[rd_ptr[ADDR_W-1:0]];

  // Set beats clear when both happen in one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_ovr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer for the UART controller. It sits directly downstream of the UART receiver and captures each completed byte when the receiver's data-ready level rises. It stores the bytes in a small first-word-fall-through FIFO and presents them to the host logic over a valid/ready interface. It also reports fill level and a sticky overrun flag.

## Interface
- ADDR_W, 3, FIFO address width; depth = 2**ADDR_W (ADDR_W ≥ 1)
- clk  in  1  system clock; all state on posedge
- rst  in  1  reset, asynchronous, active-low
- din  in  8  received byte from the receiver; stable while d_rdy_in is high
- d_rdy_in  in  1  receiver byte-ready level; may be asynchronous to clk
- dout  out  8  head-of-FIFO byte; 8'h00 when empty
- dout_valid  out  1  FIFO not empty
- dout_ready  in  1  consumer accepts dout this cycle
- count  out  ADDR_W+1  number of stored bytes, 0..2**ADDR_W
- full  out  1  count == 2**ADDR_W
- empty  out  1  count == 0
- overrun  out  1  sticky: a byte was dropped because the FIFO was full
- clr_ovr  in  1  synchronous clear of overrun

## Operation
- Reset (rst low, async): pointers = 0, count = 0, empty = 1, full = 0, dout_valid = 0, dout = 8'h00, overrun = 0, sync flops = 0. Storage contents are don't-care.
- Capture path:
  - d_rdy_in passes through two synchronizer flops (s1, s2), then one history flop (s3).
  - wr_req = s2 & ~s3, a one-cycle pulse per rising edge of d_rdy_in.
  - din is sampled directly in the wr_req cycle. No synchronizer is needed on din because din is stable while d_rdy_in is high.
- Pop: pop = dout_valid & dout_ready.
- Push: push = wr_req & (~full | pop). A push writes din to mem[wr_ptr] and increments wr_ptr.
- Drop: wr_req & full & ~pop. The byte is discarded, overrun is set to 1, and the pointers and count are unchanged.
- Overrun flag:
  - clr_ovr clears overrun on the next edge.
  - If a drop and clr_ovr occur in the same cycle, the set wins (overrun = 1).
- Pointers are ADDR_W+1 bits and wrap naturally modulo 2**(ADDR_W+1).
  - Memory index = low ADDR_W bits.
  - count = wr_ptr − rd_ptr, as a registered value or derived from the pointers.
- Count update per cycle:
  - push only: count + 1
  - pop only: count − 1
  - push and pop together: count unchanged, and both pointers advance.
- Empty with wr_req and dout_ready high: push only. No pop, since dout_valid is low.
- Full with wr_req and pop together: the byte is accepted, count stays at max, and overrun is not set.
- dout is combinational: mem[rd_ptr[ADDR_W-1:0]] when not empty, else 8'h00. dout_valid = ~empty.

## Timing
- d_rdy_in high meeting setup at clk edge k: s1 = 1 after k, s2 = 1 after k+1, wr_req high during cycle k+1..k+2.
- The write happens at edge k+2; dout_valid/count/empty update after edge k+2. Latency from d_rdy_in rise to visible data is 2–3 clk cycles.
- d_rdy_in must stay high ≥ 3 clk cycles and low ≥ 3 clk cycles between bytes. The receiver's baud-clock period guarantees this.
- A d_rdy_in level held high produces exactly one write. A new write needs a low-to-high transition.
- Pop takes effect at the edge where dout_valid & dout_ready are high. The next byte appears on dout after that edge; there is no bubble.
- full, empty, count and overrun are all registered or derived from registers, with no combinational path from dout_ready.
- Reset asserted mid-operation: all state clears immediately, and any in-flight byte is lost. After rst deasserts, a d_rdy_in that is already high is captured once, because s3 starts at 0.

## Test plan
- Reset: hold rst low, toggle d_rdy_in -> count = 0, empty = 1, dout = 8'h00, overrun = 0; no write occurs.
- Single byte: din = 8'hA5, pulse d_rdy_in high for 16 clk -> exactly one write, dout = 8'hA5, dout_valid = 1 by edge k+2, count = 1. Pop with dout_ready -> empty = 1 next cycle.
- Fill and overrun (ADDR_W = 3):
  - Write 8'h01..8'h08 -> full = 1, count = 8.
  - Write 8'h09 -> dropped, overrun = 1, count = 8.
  - Drain -> 01..08 in order.
  - Pulse clr_ovr -> overrun = 0.
- Full with simultaneous pop: FIFO full, wr_req coincides with pop of 8'h01 -> 8'h0A accepted, count stays 8, overrun stays 0, tail of FIFO reads 8'h0A.
- Wrap-around: stream 40 bytes 8'h00..8'h27 while the consumer pops every other cycle -> all 40 bytes are read in order, no overrun, and the pointers wrap several times.
- Reset mid-operation: write 3 bytes, assert rst with d_rdy_in held high, then release -> count resets to 0, then exactly one byte is captured from the held level.
